// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS BCD stopwatch: FSM state encoding and
// active-low seven-segment patterns (bit0 = a ... bit6 = g).
package stopwatch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t PAUSE = 2'd2;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes blank.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch clocked by the board clock; the 1 Hz divider output and
// the two push-buttons are sampled as asynchronous data and edge-detected.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_COUNT = 1
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        slow_in,
  input  logic        key_run_n,
  input  logic        key_clr_n,
  output logic        running,
  output logic        wrap,
  output logic [15:0] digits,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0
);

  localparam logic [7:0] TERMINAL = 8'(TICKS_PER_COUNT - 1);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized level.
  logic [2:0] slow_sync;
  logic [2:0] run_sync;
  logic [2:0] clr_sync;

  logic tick;
  logic run_evt;
  logic clr_evt;

  state_t     state;
  state_t     state_next;
  logic [7:0] prescale;
  logic       count_en;
  logic       inc;

  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;

  logic [6:0] seg3;
  logic [6:0] seg2;
  logic [6:0] seg1;
  logic [6:0] seg0;

  // Key synchronizers idle high so a released button never looks like a press
  // when reset lifts.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      slow_sync <= 3'b000;
      run_sync  <= 3'b111;
      clr_sync  <= 3'b111;
    end else begin
      slow_sync <= {slow_sync[1:0], slow_in};
      run_sync  <= {run_sync[1:0], key_run_n};
      clr_sync  <= {clr_sync[1:0], key_clr_n};
    end
  end

  assign tick    =  slow_sync[1] & ~slow_sync[2];
  assign run_evt = ~run_sync[1]  &  run_sync[2];
  assign clr_evt = ~clr_sync[1]  &  clr_sync[2];

  // Clear outranks start/stop; an unused encoding falls back to IDLE.
  // NOTE: assigning a default first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    if (clr_evt) begin
      state_next = IDLE;
    end else if (run_evt) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE && state != RUN && state != PAUSE) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign running = (state == RUN);

  // A tick coinciding with a clear or start/stop press is dropped.
  assign count_en = running & tick & ~clr_evt & ~run_evt;
  assign inc      = count_en & (prescale == TERMINAL);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      prescale <= 8'd0;
    end else if (clr_evt) begin
      prescale <= 8'd0;
    end else if (count_en) begin
      prescale <= inc ? 8'd0 : prescale + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sec_ones <= 4'd0;
      sec_tens <= 3'd0;
      min_ones <= 4'd0;
      min_tens <= 3'd0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_evt) begin
        sec_ones <= 4'd0;
        sec_tens <= 3'd0;
        min_ones <= 4'd0;
        min_tens <= 3'd0;
      end else if (inc) begin
        if (sec_ones < 4'd9) begin
          sec_ones <= sec_ones + 4'd1;
        end else begin
          sec_ones <= 4'd0;
          if (sec_tens < 3'd5) begin
            sec_tens <= sec_tens + 3'd1;
          end else begin
            sec_tens <= 3'd0;
            if (min_ones < 4'd9) begin
              min_ones <= min_ones + 4'd1;
            end else begin
              min_ones <= 4'd0;
              if (min_tens < 3'd5) begin
                min_tens <= min_tens + 3'd1;
              end else begin
                min_tens <= 3'd0;
                wrap     <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign digits = {1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};

  seg7_decoder u_dec3 (.bcd(digits[15:12]), .seg(seg3));
  seg7_decoder u_dec2 (.bcd(digits[11:8]),  .seg(seg2));
  seg7_decoder u_dec1 (.bcd(digits[7:4]),   .seg(seg1));
  seg7_decoder u_dec0 (.bcd(digits[3:0]),   .seg(seg0));

  // Registered segment drive keeps the display pins glitch-free; one cycle
  // behind digits.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      hex3 <= SEG_0;
      hex2 <= SEG_0;
      hex1 <= SEG_0;
      hex0 <= SEG_0;
    end else begin
      hex3 <= seg3;
      hex2 <= seg2;
      hex1 <= seg1;
      hex0 <= seg0;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: two instances (1 and 3 ticks per count) share the
// stimulus and are compared with a seconds-count model of the stopwatch.
module tb_stopwatch_bcd;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk_in = 1'b0;
  logic rst;
  logic slow_in;
  logic key_run_n;
  logic key_clr_n;

  logic        running1, wrap1;
  logic [15:0] digits1;
  logic [6:0]  hex3_1, hex2_1, hex1_1, hex0_1;
  logic        running3, wrap3;
  logic [15:0] digits3;
  logic [6:0]  hex3_3, hex2_3, hex1_3, hex0_3;

  int n_checks = 0;
  int n_errors = 0;
  int mode = M_IDLE;
  int tick_total = 0;
  int wrap_cnt = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  stopwatch_bcd #(.TICKS_PER_COUNT(1)) dut1 (
    .clk_in(clk_in), .rst(rst), .slow_in(slow_in),
    .key_run_n(key_run_n), .key_clr_n(key_clr_n),
    .running(running1), .wrap(wrap1), .digits(digits1),
    .hex3(hex3_1), .hex2(hex2_1), .hex1(hex1_1), .hex0(hex0_1)
  );

  stopwatch_bcd #(.TICKS_PER_COUNT(3)) dut3 (
    .clk_in(clk_in), .rst(rst), .slow_in(slow_in),
    .key_run_n(key_run_n), .key_clr_n(key_clr_n),
    .running(running3), .wrap(wrap3), .digits(digits3),
    .hex3(hex3_3), .hex2(hex2_3), .hex1(hex1_3), .hex0(hex0_3)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (wrap1) wrap_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] bcd_of(int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic tick(input int hi, input int lo);
    slow_in = 1'b1;
    step(hi);
    slow_in = 1'b0;
    step(lo);
    if (mode == M_RUN) tick_total++;
  endtask

  task automatic press_run();
    key_run_n = 1'b0;
    step(2);
    key_run_n = 1'b1;
    step(2);
    case (mode)
      M_IDLE:  mode = M_RUN;
      M_RUN:   mode = M_PAUSE;
      default: mode = M_RUN;
    endcase
  endtask

  task automatic press_clr();
    key_clr_n = 1'b0;
    step(2);
    key_clr_n = 1'b1;
    step(2);
    mode = M_IDLE;
    tick_total = 0;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] e1, e3;
    step(3);
    e1 = bcd_of(tick_total % 3600);
    e3 = bcd_of((tick_total / 3) % 3600);
    chk({tag, "/running1"}, 32'(running1), 32'(mode == M_RUN));
    chk({tag, "/wrap1"},    32'(wrap1), 32'd0);
    chk({tag, "/digits1"},  32'(digits1), 32'(e1));
    chk({tag, "/hex0_1"},   32'(hex0_1), 32'(seg_tab[e1[3:0]]));
    chk({tag, "/hex1_1"},   32'(hex1_1), 32'(seg_tab[e1[7:4]]));
    chk({tag, "/hex2_1"},   32'(hex2_1), 32'(seg_tab[e1[11:8]]));
    chk({tag, "/hex3_1"},   32'(hex3_1), 32'(seg_tab[e1[15:12]]));
    chk({tag, "/running3"}, 32'(running3), 32'(mode == M_RUN));
    chk({tag, "/digits3"},  32'(digits3), 32'(e3));
    chk({tag, "/hex0_3"},   32'(hex0_3), 32'(seg_tab[e3[3:0]]));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "/running1"}, 32'(running1), 32'd0);
    chk({tag, "/wrap1"},    32'(wrap1), 32'd0);
    chk({tag, "/digits1"},  32'(digits1), 32'h0000);
    chk({tag, "/hex_1"},    32'({hex3_1, hex2_1, hex1_1, hex0_1}),
        32'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}));
    chk({tag, "/running3"}, 32'(running3), 32'd0);
    chk({tag, "/digits3"},  32'(digits3), 32'h0000);
    chk({tag, "/hex_3"},    32'({hex3_3, hex2_3, hex1_3, hex0_3}),
        32'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}));
  endtask

  initial begin
    int r;
    rst = 1'b0;
    slow_in = 1'b0;
    key_run_n = 1'b1;
    key_clr_n = 1'b1;

    // Reset held with random input activity.
    repeat (6) begin
      @(negedge clk_in);
      slow_in   = 1'($urandom);
      key_run_n = 1'($urandom);
      key_clr_n = 1'($urandom);
    end
    check_reset("reset_hold");
    slow_in = 1'b0;
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
    step(1);
    rst = 1'b1;
    step(5);
    check_all("reset_release");

    // Basic count, then slow_in toggling every cycle.
    press_run();
    repeat (10) tick($urandom_range(1, 3), $urandom_range(1, 3));
    check_all("basic10");
    chk("basic10/const", 32'(digits1), 32'h0010);
    chk("basic10/hex1", 32'(hex1_1), 32'(7'b1111001));
    repeat (20) begin
      slow_in = ~slow_in;
      step(1);
    end
    tick_total += 10;
    check_all("toggle_each_cycle");
    chk("toggle/const", 32'(digits1), 32'h0020);

    // Pause holds the count.
    press_clr();
    press_run();
    repeat (7) tick(1, 1);
    check_all("pause_pre");
    press_run();
    repeat (20) tick(1, 2);
    check_all("paused");
    chk("paused/const", 32'(digits1), 32'h0007);
    press_run();
    repeat (3) tick(2, 1);
    check_all("resumed");
    chk("resumed/const", 32'(digits1), 32'h0010);

    // Wrap 59:59 -> 00:00 with cycle-exact wrap pulse.
    press_clr();
    press_run();
    repeat (3599) tick(1, 1);
    check_all("at_5959");
    chk("at_5959/const", 32'(digits1), 32'h5959);
    wrap_cnt = 0;
    slow_in = 1'b1;
    step(1);
    slow_in = 1'b0;
    step(1);
    chk("wrap/before", 32'(wrap1), 32'd0);
    step(1);
    chk("wrap/pulse", 32'(wrap1), 32'd1);
    chk("wrap/digits", 32'(digits1), 32'h0000);
    chk("wrap/hex_lag", 32'(hex0_1), 32'(7'b0010000));
    step(1);
    chk("wrap/after", 32'(wrap1), 32'd0);
    chk("wrap/hex0", 32'(hex0_1), 32'(7'b1000000));
    chk("wrap/running", 32'(running1), 32'd1);
    tick_total++;
    check_all("post_wrap");
    chk("wrap/count", 32'(wrap_cnt), 32'd1);

    // Clear, run and tick in the same cycle while running at 00:42.
    press_clr();
    press_run();
    repeat (42) tick(1, 1);
    check_all("at_0042");
    key_clr_n = 1'b0;
    key_run_n = 1'b0;
    slow_in = 1'b1;
    step(1);
    slow_in = 1'b0;
    step(1);
    key_clr_n = 1'b1;
    key_run_n = 1'b1;
    step(2);
    mode = M_IDLE;
    tick_total = 0;
    check_all("simultaneous");

    // Randomized sequences of presses and ticks.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 19);
      if (r < 3) begin
        press_run();
      end else if (r == 3) begin
        press_clr();
      end else begin
        repeat ($urandom_range(1, 20)) tick($urandom_range(1, 3), $urandom_range(1, 3));
      end
      check_all("random");
    end

    // Asynchronous reset mid-run at 12:34.
    press_clr();
    press_run();
    repeat (754) tick(1, 1);
    check_all("at_1234");
    chk("at_1234/const", 32'(digits1), 32'h1234);
    @(negedge clk_in);
    #2 rst = 1'b0;
    #1 check_reset("async_reset");
    mode = M_IDLE;
    tick_total = 0;
    @(negedge clk_in);
    rst = 1'b1;
    step(3);
    check_all("after_async_reset");
    press_run();
    repeat (9) tick($urandom_range(1, 2), $urandom_range(1, 2));
    check_all("prescale3");
    chk("prescale3/const", 32'(digits3), 32'h0003);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
